// File: rtl/reaction_pkg.sv
// reaction_pkg: shared definitions for the reaction-timer blocks.
//   state_t        - measurement FSM states (2-bit encoding)
//   BCD_MAX_DIGIT  - largest legal BCD digit value
//   NUM_DIGITS     - number of BCD digits in the ms count
//   DEFAULT_CLK_HZ - default system clock frequency
package reaction_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
    localparam int         NUM_DIGITS     = 4;
    localparam int         DEFAULT_CLK_HZ = 50_000_000;
endpackage

// File: rtl/reaction_ms_counter_if.sv
// reaction_ms_counter_if: control inputs and result outputs of the
// reaction ms counter.
//   clear, start_clock, stop_clock - controls from the reaction-timer FSM
//   bcd0..bcd3                     - ms result digits, units first
//   busy, valid, overflow          - status flags
//   cheat                          - stop before start (RCNT_CHEAT_DETECT_EN only)
// master drives the controls, slave (the counter) drives the results.
interface reaction_ms_counter_if;
    logic       clear;
    logic       start_clock;
    logic       stop_clock;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic [3:0] bcd2;
    logic [3:0] bcd3;
    logic       busy;
    logic       valid;
    logic       overflow;
`ifdef RCNT_CHEAT_DETECT_EN
    logic       cheat;
`endif

    modport master (
        output clear, start_clock, stop_clock,
`ifdef RCNT_CHEAT_DETECT_EN
        input  cheat,
`endif
        input  bcd0, bcd1, bcd2, bcd3, busy, valid, overflow
    );

    modport slave (
        input  clear, start_clock, stop_clock,
`ifdef RCNT_CHEAT_DETECT_EN
        output cheat,
`endif
        output bcd0, bcd1, bcd2, bcd3, busy, valid, overflow
    );
endinterface

// File: rtl/bcd4_counter.sv
// bcd4_counter: NUM_DIGITS cascaded BCD digits that saturate at all nines.
//   clk, reset - clock, async active-high reset
//   clr        - synchronous clear to zero (highest synchronous priority)
//   set_max    - load all nines
//   inc        - increment by one unless already saturated
//   sat        - all digits are 9
//   digits     - BCD value, digits[0] is the units digit
module bcd4_counter
    import reaction_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inc,
    input  logic                       clr,
    input  logic                       set_max,
    output logic                       sat,
    output logic [NUM_DIGITS-1:0][3:0] digits
);
    logic [NUM_DIGITS-1:0][3:0] r_digits;
    logic [NUM_DIGITS-1:0][3:0] w_next;
    logic                       w_carry;
    logic                       w_sat;

    // Ripple the +1 upward: a 9 wraps to 0 and passes the carry on.
    always_comb begin
        w_next  = r_digits;
        w_carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_carry) begin
                if (r_digits[i] == BCD_MAX_DIGIT) begin
                    w_next[i] = 4'd0;
                end else begin
                    w_next[i] = r_digits[i] + 4'd1;
                    w_carry   = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_sat = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digits[i] != BCD_MAX_DIGIT) w_sat = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digits <= '0;
        end else if (clr) begin
            r_digits <= '0;
        end else if (set_max) begin
            r_digits <= {NUM_DIGITS{BCD_MAX_DIGIT}};
        end else if (inc && !w_sat) begin
            r_digits <= w_next;
        end
    end

    assign sat    = w_sat;
    assign digits = r_digits;
endmodule

// File: rtl/reaction_ms_counter.sv
// reaction_ms_counter: measures milliseconds between a start_clock rising
// edge and a stop_clock rising edge as 4-digit BCD (0000-9999), then holds
// the result.
//   clk   - system clock
//   reset - async active-high reset
//   bus   - reaction_ms_counter_if.slave (controls in, digits/flags out)
// Parameters: CLK_HZ system clock in Hz; TICK_DIV clocks per ms (>= 2).
// Optional macro RCNT_CHEAT_DETECT_EN: a stop edge while IDLE flags cheat,
// loads 9999 and holds it as a valid result.
module reaction_ms_counter
    import reaction_pkg::*;
#(
    parameter int CLK_HZ   = DEFAULT_CLK_HZ,
    parameter int TICK_DIV = CLK_HZ / 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    reaction_ms_counter_if.slave        bus
);
    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t                     r_state;
    logic [PW-1:0]              r_presc;
    logic                       r_start_d;
    logic                       r_stop_d;
    logic                       r_busy;
    logic                       r_valid;
    logic                       r_overflow;
    logic                       w_start_rise;
    logic                       w_stop_rise;
    logic                       w_tick;
    logic                       w_restart;
    logic                       w_set_max;
    logic                       w_sat;
    logic [NUM_DIGITS-1:0][3:0] w_digits;

    assign w_start_rise = bus.start_clock & ~r_start_d;
    assign w_stop_rise  = bus.stop_clock  & ~r_stop_d;
    assign w_tick       = (r_state == COUNT) && (r_presc == PRESC_MAX);
    // A start edge outside COUNT (IDLE or HOLD) begins a fresh measurement.
    assign w_restart    = w_start_rise && (r_state != COUNT);

`ifdef RCNT_CHEAT_DETECT_EN
    logic r_cheat;
    assign w_set_max = !bus.clear && (r_state == IDLE) && w_stop_rise && !w_start_rise;
    assign bus.cheat = r_cheat;
`else
    assign w_set_max = 1'b0;
`endif

    bcd4_counter u_bcd (
        .clk     (clk),
        .reset   (reset),
        .inc     (w_tick),
        .clr     (bus.clear | w_restart),
        .set_max (w_set_max),
        .sat     (w_sat),
        .digits  (w_digits)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_presc    <= '0;
            r_start_d  <= 1'b0;
            r_stop_d   <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
`ifdef RCNT_CHEAT_DETECT_EN
            r_cheat    <= 1'b0;
`endif
        end else begin
            r_start_d <= bus.start_clock;
            r_stop_d  <= bus.stop_clock;
            if (bus.clear) begin
                r_state    <= IDLE;
                r_presc    <= '0;
                r_busy     <= 1'b0;
                r_valid    <= 1'b0;
                r_overflow <= 1'b0;
`ifdef RCNT_CHEAT_DETECT_EN
                r_cheat    <= 1'b0;
`endif
            end else begin
                case (r_state)
                    IDLE, HOLD: begin
                        if (w_start_rise) begin
                            r_presc    <= '0;
                            r_overflow <= 1'b0;
`ifdef RCNT_CHEAT_DETECT_EN
                            r_cheat    <= 1'b0;
`endif
                            // Simultaneous stop: a zero-length measurement.
                            if (w_stop_rise) begin
                                r_state <= HOLD;
                                r_busy  <= 1'b0;
                                r_valid <= 1'b1;
                            end else begin
                                r_state <= COUNT;
                                r_busy  <= 1'b1;
                                r_valid <= 1'b0;
                            end
                        end
`ifdef RCNT_CHEAT_DETECT_EN
                        else if (r_state == IDLE && w_stop_rise) begin
                            r_state <= HOLD;
                            r_valid <= 1'b1;
                            r_cheat <= 1'b1;
                        end
`endif
                    end
                    COUNT: begin
                        r_presc <= w_tick ? '0 : r_presc + 1'b1;
                        // Overflow means a tick arrived with nowhere to go.
                        if (w_tick && w_sat) r_overflow <= 1'b1;
                        if (w_stop_rise) begin
                            r_state <= HOLD;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.bcd0     = w_digits[0];
    assign bus.bcd1     = w_digits[1];
    assign bus.bcd2     = w_digits[2];
    assign bus.bcd3     = w_digits[3];
    assign bus.busy     = r_busy;
    assign bus.valid    = r_valid;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_reaction_ms_counter.sv
// tb_reaction_ms_counter: directed vectors for reaction_ms_counter.
// dut_a uses TICK_DIV=10; dut_b uses TICK_DIV=2 so saturation is reachable
// in a short run. Both see the same stimulus; only the relevant one is checked.
module tb_reaction_ms_counter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    reaction_ms_counter_if bus_a ();
    reaction_ms_counter_if bus_b ();

    assign bus_a.clear = clear;
    assign bus_a.start_clock = start;
    assign bus_a.stop_clock = stop;
    assign bus_b.clear = clear;
    assign bus_b.start_clock = start;
    assign bus_b.stop_clock = stop;

    reaction_ms_counter #(.CLK_HZ(10_000), .TICK_DIV(10)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    reaction_ms_counter #(.CLK_HZ(2_000), .TICK_DIV(2)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    always #5 clk = ~clk;

    // {cheat, overflow, valid, busy, bcd3, bcd2, bcd1, bcd0}
    function automatic logic [19:0] snap_a();
        logic ch;
`ifdef RCNT_CHEAT_DETECT_EN
        ch = bus_a.cheat;
`else
        ch = 1'b0;
`endif
        return {ch, bus_a.overflow, bus_a.valid, bus_a.busy,
                bus_a.bcd3, bus_a.bcd2, bus_a.bcd1, bus_a.bcd0};
    endfunction

    function automatic logic [19:0] snap_b();
        logic ch;
`ifdef RCNT_CHEAT_DETECT_EN
        ch = bus_b.cheat;
`else
        ch = 1'b0;
`endif
        return {ch, bus_b.overflow, bus_b.valid, bus_b.busy,
                bus_b.bcd3, bus_b.bcd2, bus_b.bcd1, bus_b.bcd0};
    endfunction

    function automatic logic [19:0] ex(logic busy, logic valid, logic ovf,
                                       logic ch, logic [15:0] bcd);
        return {ch, ovf, valid, busy, bcd};
    endfunction

    task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got ch/ov/va/bu=%b%b%b%b bcd=%h, want %b%b%b%b bcd=%h",
                     name, got[19], got[18], got[17], got[16], got[15:0],
                     exp[19], exp[18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic        s;
        logic        p;
        logic        c;
        int          n;
        logic [19:0] exp;
    } vec_t;

    vec_t tv[23];
    int   bad_digits;

    initial begin
        tv[0]  = '{1'b0, 1'b0, 1'b0, 2,   ex(0, 0, 0, 0, 16'h0000)};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 1,   ex(1, 0, 0, 0, 16'h0000)};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 124, ex(1, 0, 0, 0, 16'h0012)};
        tv[3]  = '{1'b1, 1'b1, 1'b0, 1,   ex(0, 1, 0, 0, 16'h0012)};
        tv[4]  = '{1'b1, 1'b1, 1'b0, 20,  ex(0, 1, 0, 0, 16'h0012)};
        tv[5]  = '{1'b0, 1'b0, 1'b0, 1,   ex(0, 1, 0, 0, 16'h0012)};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 1,   ex(0, 1, 0, 0, 16'h0012)};
        tv[7]  = '{1'b1, 1'b1, 1'b0, 1,   ex(1, 0, 0, 0, 16'h0000)};
        tv[8]  = '{1'b1, 1'b1, 1'b0, 10,  ex(1, 0, 0, 0, 16'h0001)};
        tv[9]  = '{1'b1, 1'b0, 1'b0, 1,   ex(1, 0, 0, 0, 16'h0001)};
        tv[10] = '{1'b1, 1'b1, 1'b0, 1,   ex(0, 1, 0, 0, 16'h0001)};
        tv[11] = '{1'b1, 1'b1, 1'b1, 1,   ex(0, 0, 0, 0, 16'h0000)};
        tv[12] = '{1'b0, 1'b0, 1'b0, 1,   ex(0, 0, 0, 0, 16'h0000)};
        tv[13] = '{1'b1, 1'b1, 1'b0, 1,   ex(0, 1, 0, 0, 16'h0000)};
        tv[14] = '{1'b0, 1'b0, 1'b1, 1,   ex(0, 0, 0, 0, 16'h0000)};
        tv[15] = '{1'b1, 1'b0, 1'b0, 1,   ex(1, 0, 0, 0, 16'h0000)};
        tv[16] = '{1'b1, 1'b0, 1'b0, 9,   ex(1, 0, 0, 0, 16'h0000)};
        tv[17] = '{1'b1, 1'b1, 1'b0, 1,   ex(0, 1, 0, 0, 16'h0001)};
        tv[18] = '{1'b0, 1'b0, 1'b1, 1,   ex(0, 0, 0, 0, 16'h0000)};
`ifdef RCNT_CHEAT_DETECT_EN
        tv[19] = '{1'b0, 1'b1, 1'b0, 1,   ex(0, 1, 0, 1, 16'h9999)};
        tv[20] = '{1'b0, 1'b0, 1'b0, 1,   ex(0, 1, 0, 1, 16'h9999)};
`else
        tv[19] = '{1'b0, 1'b1, 1'b0, 1,   ex(0, 0, 0, 0, 16'h0000)};
        tv[20] = '{1'b0, 1'b0, 1'b0, 1,   ex(0, 0, 0, 0, 16'h0000)};
`endif
        tv[21] = '{1'b1, 1'b0, 1'b0, 1,   ex(1, 0, 0, 0, 16'h0000)};
        tv[22] = '{1'b0, 1'b0, 1'b1, 1,   ex(0, 0, 0, 0, 16'h0000)};

        // Reset state while reset is held.
        cyc(3);
        chk("reset_a", snap_a(), 20'h0);
        chk("reset_b", snap_b(), 20'h0);
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            start = tv[i].s;
            stop  = tv[i].p;
            clear = tv[i].c;
            cyc(tv[i].n);
            chk($sformatf("vec%0d", i), snap_a(), tv[i].exp);
        end
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        cyc(1);

        // Carry 0099 -> 0100, scanning every digit for illegal values.
        start = 1'b1;
        cyc(1);
        bad_digits = 0;
        for (int k = 0; k < 1000; k++) begin
            cyc(1);
            if (bus_a.bcd0 > 4'd9 || bus_a.bcd1 > 4'd9 ||
                bus_a.bcd2 > 4'd9 || bus_a.bcd3 > 4'd9) bad_digits++;
            if (k == 989) chk("carry_0099", snap_a(), ex(1, 0, 0, 0, 16'h0099));
        end
        chk("carry_0100", snap_a(), ex(1, 0, 0, 0, 16'h0100));
        n_tests++;
        if (bad_digits != 0) begin
            n_fail++;
            $display("FAIL digit_range: got %0d illegal samples, want 0", bad_digits);
        end

        // Async reset mid-count at 0005, then a fresh count from 0000.
        clear = 1'b1; start = 1'b0; cyc(1);
        clear = 1'b0; cyc(1);
        start = 1'b1; cyc(1);
        cyc(50);
        chk("pre_reset_0005", snap_a(), ex(1, 0, 0, 0, 16'h0005));
        reset = 1'b1;
        #1;
        chk("async_reset", snap_a(), 20'h0);
        start = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        chk("post_reset_idle", snap_a(), 20'h0);
        start = 1'b1; cyc(1);
        cyc(30);
        chk("recount_0003", snap_a(), ex(1, 0, 0, 0, 16'h0003));

        // HOLD at 0042, restart, then clear out of HOLD.
        clear = 1'b1; start = 1'b0; cyc(1);
        clear = 1'b0; cyc(1);
        start = 1'b1; cyc(1);
        cyc(420);
        stop = 1'b1; cyc(1);
        chk("hold_0042", snap_a(), ex(0, 1, 0, 0, 16'h0042));
        start = 1'b0; cyc(1);
        start = 1'b1; cyc(1);
        chk("restart_from_hold", snap_a(), ex(1, 0, 0, 0, 16'h0000));
        cyc(10);
        chk("restart_counts", snap_a(), ex(1, 0, 0, 0, 16'h0001));
        stop = 1'b0; cyc(1);
        stop = 1'b1; cyc(1);
        chk("hold_0001", snap_a(), ex(0, 1, 0, 0, 16'h0001));
        clear = 1'b1; cyc(1);
        clear = 1'b0;
        chk("clear_from_hold", snap_a(), 20'h0);

        // Saturation on the fast instance: 9999 at 19998 edges, overflow after.
        start = 1'b0; stop = 1'b0; cyc(1);
        start = 1'b1; cyc(1);
        cyc(19998);
        chk("sat_9999_no_ovf", snap_b(), ex(1, 0, 0, 0, 16'h9999));
        cyc(2);
        chk("sat_ovf", snap_b(), ex(1, 0, 1, 0, 16'h9999));
        cyc(50);
        chk("sat_holds", snap_b(), ex(1, 0, 1, 0, 16'h9999));
        stop = 1'b1; cyc(1);
        chk("sat_stop_hold", snap_b(), ex(0, 1, 1, 0, 16'h9999));
        start = 1'b0; stop = 1'b0; cyc(1);
        start = 1'b1; cyc(1);
        chk("ovf_cleared_on_start", snap_b(), ex(1, 0, 0, 0, 16'h0000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
